// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and helpers for the demux_tree_stream tree.
package demux_pkg;
   localparam int PERF_W = 16;
   function automatic int num_out(input int sel_w);
      return 1 << sel_w;
   endfunction
endpackage

// File: rtl/demux1to2_stage.sv
// demux1to2_stage: one-entry registered 1-to-2 stage steered by i_sel[BIT].
module demux1to2_stage import demux_pkg::*; #(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 2,
   parameter int BIT    = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   input  logic [SEL_W-1:0]  i_sel,
   output logic [1:0]        o_valid,
   input  logic [1:0]        i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic [SEL_W-1:0]  o_sel,
   output logic              o_busy
);
   typedef struct packed {
      logic              vld;
      logic [SEL_W-1:0]  sel;
      logic [DATA_W-1:0] data;
   } stage_t;
   stage_t r_st;
   logic   w_side;
   assign w_side  = r_st.sel[BIT];
   assign o_ready = !r_st.vld || i_ready[w_side];
   assign o_valid = {r_st.vld && w_side, r_st.vld && !w_side};
   assign o_data  = r_st.data;
   assign o_sel   = r_st.sel;
   assign o_busy  = r_st.vld;
   // A drain and a load in the same cycle leave the new beat in the register.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_st <= '0;
      else if (i_valid && o_ready) r_st <= '{vld: 1'b1, sel: i_sel, data: i_data};
      else if (o_ready) r_st.vld <= 1'b0;
endmodule

// File: rtl/demux_tree_stream.sv
// demux_tree_stream: pipelined 1-to-2**SEL_W stream demux built from a tree of
// registered 1-to-2 stages. Define DEMUX_PERF_EN to add perf_xfer/perf_stall counters.
module demux_tree_stream import demux_pkg::*; #(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DATA_W-1:0]           in_data,
   input  logic [SEL_W-1:0]            in_sel,
   output logic [2**SEL_W-1:0]         out_valid,
   input  logic [2**SEL_W-1:0]         out_ready,
   output logic [2**SEL_W*DATA_W-1:0]  out_data,
`ifdef DEMUX_PERF_EN
   output logic [PERF_W-1:0]           perf_xfer,
   output logic [PERF_W-1:0]           perf_stall,
`endif
   output logic                        busy
);
   localparam int N  = num_out(SEL_W);
   localparam int NS = N - 1;
   // Stages are numbered heap-style: node I has children 2I+1 (bit 0) and 2I+2 (bit 1).
   logic              w_v  [NS];
   logic              w_r  [NS];
   logic [DATA_W-1:0] w_d  [NS];
   logic [SEL_W-1:0]  w_s  [NS];
   logic [1:0]        w_ov [NS];
   logic [1:0]        w_ir [NS];
   logic [DATA_W-1:0] w_od [NS];
   logic [SEL_W-1:0]  w_os [NS];
   logic [NS-1:0]     w_busy;
   for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
      for (genvar j = 0; j < 2**k; j++) begin : g_node
         localparam int I = 2**k - 1 + j;
         if (k == 0) begin : g_root
            assign w_v[I]   = in_valid;
            assign w_d[I]   = in_data;
            assign w_s[I]   = in_sel;
            assign in_ready = w_r[I];
         end else begin : g_child
            localparam int P = (I - 1) / 2;
            assign w_v[I] = w_ov[P][(I - 1) % 2];
            assign w_d[I] = w_od[P];
            assign w_s[I] = w_os[P];
         end
         if (k == SEL_W - 1) begin : g_leaf
            assign w_ir[I]                                = out_ready[2*j +: 2];
            assign out_valid[2*j +: 2]                    = w_ov[I];
            assign out_data[2*j*DATA_W +: DATA_W]         = w_od[I];
            assign out_data[(2*j + 1)*DATA_W +: DATA_W]   = w_od[I];
         end else begin : g_inner
            assign w_ir[I] = {w_r[2*I + 2], w_r[2*I + 1]};
         end
         demux1to2_stage #(
            .DATA_W (DATA_W),
            .SEL_W  (SEL_W),
            .BIT    (SEL_W - 1 - k)
         ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (w_v[I]),
            .o_ready (w_r[I]),
            .i_data  (w_d[I]),
            .i_sel   (w_s[I]),
            .o_valid (w_ov[I]),
            .i_ready (w_ir[I]),
            .o_data  (w_od[I]),
            .o_sel   (w_os[I]),
            .o_busy  (w_busy[I])
         );
      end
   end
   assign busy = |w_busy;
`ifdef DEMUX_PERF_EN
   logic [PERF_W-1:0] r_xfer;
   logic [PERF_W-1:0] r_stall;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_xfer  <= '0;
         r_stall <= '0;
      end else begin
         if (in_valid && in_ready && r_xfer != '1) r_xfer <= r_xfer + PERF_W'(1);
         if (in_valid && !in_ready && r_stall != '1) r_stall <= r_stall + PERF_W'(1);
      end
   assign perf_xfer  = r_xfer;
   assign perf_stall = r_stall;
`endif
endmodule

// File: tb/tb_demux_tree_stream.sv
// tb_demux_tree_stream: directed + randomized bench with per-output queue scoreboard.
module tb_demux_tree_stream;
   localparam int DW = 8;
   localparam int SW = 2;
   localparam int N  = 4;
   logic            clk = 0;
   logic            rst_n = 0;
   logic            in_valid = 0;
   logic            in_ready;
   logic [DW-1:0]   in_data = '0;
   logic [SW-1:0]   in_sel = '0;
   logic [N-1:0]    out_valid;
   logic [N-1:0]    out_ready = '1;
   logic [N*DW-1:0] out_data;
   logic            busy;
`ifdef DEMUX_PERF_EN
   logic [15:0]     perf_xfer, perf_stall;
`endif
   int n_chk = 0;
   int n_err = 0;
   int idx;
   logic [DW-1:0] d [8];
   logic [SW-1:0] s [8];
   always #5 clk = ~clk;
   demux_tree_stream #(.DATA_W(DW), .SEL_W(SW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
`ifdef DEMUX_PERF_EN
      .perf_xfer  (perf_xfer),
      .perf_stall (perf_stall),
`endif
      .busy       (busy)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   // Reference model: one FIFO per output in acceptance order, plus an in-flight count.
   logic [DW-1:0] q [N][$];
   int            inflight;
   logic [N-1:0]  prev_stall;
   logic [DW-1:0] prev_data [N];
   int            exp_xfer, exp_stall;
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) q[i].delete();
         inflight = 0;
         prev_stall = '0;
         exp_xfer = 0;
         exp_stall = 0;
      end else begin
         chk("busy", 32'(busy), 32'(inflight != 0));
         if (inflight == 0) chk("idle_ready", 32'(in_ready), 1);
`ifdef DEMUX_PERF_EN
         chk("perf_xfer", 32'(perf_xfer), exp_xfer);
         chk("perf_stall", 32'(perf_stall), exp_stall);
`endif
         for (int i = 0; i < N; i++) begin
            if (prev_stall[i]) begin
               chk("hold_valid", 32'(out_valid[i]), 1);
               chk("hold_data", 32'(out_data[i*DW +: DW]), 32'(prev_data[i]));
            end
            if (out_valid[i] && out_ready[i]) begin
               if (q[i].size() == 0) chk("spurious_beat", q[i].size(), 1);
               else begin
                  chk("out_data", 32'(out_data[i*DW +: DW]), 32'(q[i].pop_front()));
                  inflight--;
               end
            end
            prev_stall[i] = out_valid[i] && !out_ready[i];
            prev_data[i]  = out_data[i*DW +: DW];
         end
         if (in_valid && in_ready) begin
            q[in_sel].push_back(in_data);
            inflight++;
            if (exp_xfer < 65535) exp_xfer++;
         end
         if (in_valid && !in_ready && exp_stall < 65535) exp_stall++;
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push(input logic [SW-1:0] sel, input logic [DW-1:0] data);
      int c;
      in_valid = 1;
      in_sel   = sel;
      in_data  = data;
      for (c = 0; c < 30; c++) begin
         @(negedge clk);
         if (in_ready) break;
         tick();
      end
      chk("push_timeout", c, c < 30 ? c : 0);
      tick();
      in_valid = 0;
   endtask
   task automatic drain(input string tag);
      in_valid  = 0;
      out_ready = '1;
      for (int c = 0; c < 20 && busy; c++) tick();
      @(negedge clk);
      chk(tag, 32'(busy), 0);
      chk({tag, "_queues"}, q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
      tick();
   endtask
   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      #12;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_out_data", out_data, 0);
      tick();
      rst_n = 1;
      tick();
`ifdef DEMUX_PERF_EN
      // 5 cycles offered to a stalled lane: 2 accepted, 3 stalled; then 3 more accepted.
      out_ready = 4'b1101;
      in_valid = 1;
      in_sel = 1;
      for (int c = 0; c < 5; c++) begin
         in_data = 8'(c);
         tick();
      end
      in_valid = 0;
      out_ready = '1;
      tick();
      push(1, 8'h10);
      push(1, 8'h11);
      push(1, 8'h12);
      drain("perf_drain");
      chk("perf_xfer5", 32'(perf_xfer), 5);
      chk("perf_stall3", 32'(perf_stall), 3);
      in_valid = 1;
      for (int c = 0; c < 70000; c++) begin
         in_sel  = 2'($urandom);
         in_data = 8'($urandom);
         tick();
      end
      drain("perf_sat_drain");
      chk("perf_sat", 32'(perf_xfer), 32'hFFFF);
`endif
      // Test 1: single beat latency
      out_ready = '1;
      in_valid = 1;
      in_sel = 2;
      in_data = 8'hA5;
      @(negedge clk);
      chk("t1_accept", 32'(in_ready), 1);
      tick();
      in_valid = 0;
      @(negedge clk);
      chk("t1_early", 32'(out_valid), 0);
      tick();
      @(negedge clk);
      chk("t1_valid", 32'(out_valid), 4'b0100);
      chk("t1_data", 32'(out_data[23:16]), 8'hA5);
      tick();
      drain("t1_drain");
      // Test 2: back-to-back streaming, fixed 2-cycle latency
      for (int i = 0; i < 8; i++) begin
         s[i] = 2'(i % 4);
         d[i] = 8'($urandom);
      end
      for (int c = 0; c < 10; c++) begin
         in_valid = c < 8;
         if (c < 8) begin
            in_sel  = s[c];
            in_data = d[c];
         end
         @(negedge clk);
         if (c < 8) chk("t2_ready", 32'(in_ready), 1);
         if (c >= 2) begin
            chk("t2_valid", 32'(out_valid), 32'(1) << s[c-2]);
            chk("t2_data", 32'(out_data[s[c-2]*DW +: DW]), 32'(d[c-2]));
         end
         tick();
      end
      drain("t2_drain");
      // Test 3: backpressure on lane 1 fills leaf then root
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
      out_ready = 4'b1101;
      in_valid = 1;
      in_sel = 1;
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         in_data = d[idx];
         @(negedge clk);
         chk("t3_ready", 32'(in_ready), c < 2 ? 1 : 0);
         if (c >= 2) begin
            chk("t3_valid", 32'(out_valid), 4'b0010);
            chk("t3_hold", 32'(out_data[15:8]), 8'h11);
         end
         if (in_ready) idx++;
         tick();
      end
      out_ready = '1;
      for (int c = 0; c < 10 && idx < 3; c++) begin
         in_data = d[idx];
         @(negedge clk);
         if (in_ready) idx++;
         tick();
      end
      chk("t3_all_accepted", idx, 3);
      drain("t3_drain");
      // Test 4: head-of-line blocking behind a stalled lane 0
      out_ready = 4'b1110;
      push(0, 8'hA0);
      push(1, 8'hB1);
      in_valid = 1;
      in_sel = 2;
      in_data = 8'hC2;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t4_blocked", 32'(in_ready), 0);
         chk("t4_valid", 32'(out_valid), 4'b0001);
         tick();
      end
      out_ready = '1;
      idx = 0;
      for (int c = 0; c < 10 && idx == 0; c++) begin
         @(negedge clk);
         if (in_ready) idx = 1;
         tick();
      end
      chk("t4_c_accepted", idx, 1);
      drain("t4_drain");
      // Test 5: reset with beats in flight
      push(3, 8'h5A);
      push(0, 8'h6B);
      #2 rst_n = 0;
      #1;
      chk("t5_out_valid", 32'(out_valid), 0);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_in_ready", 32'(in_ready), 1);
      chk("t5_out_data", out_data, 0);
      tick();
      rst_n = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("t5_no_replay", 32'(out_valid), 0);
         tick();
      end
      // Randomized traffic against the queue model
      for (int c = 0; c < 2000; c++) begin
         in_valid  = $urandom_range(0, 9) < 7;
         in_sel    = 2'($urandom);
         in_data   = 8'($urandom);
         out_ready = 4'($urandom) | 4'($urandom);
         tick();
      end
      drain("rand_drain");
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
